// File: rtl/pp_gen_row_stream.sv
// Partial-product generator: for each A(i,k), walks CSR row k of B and streams
// A(i,k)*B(k,j) in ascending j through a 2-entry output FIFO to the merge core.
module pp_gen_row_stream #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_val,
  input  logic [IDX_W-1:0]  a_row,
  input  logic [IDX_W-1:0]  a_col,
  input  logic              a_last,
  output logic              ptr_rd_en,
  output logic [IDX_W-1:0]  ptr_rd_addr,
  input  logic [ADDR_W-1:0] ptr_start,
  input  logic [ADDR_W-1:0] ptr_end,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_val,
  input  logic [IDX_W-1:0]  b_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_STREAM, S_EMPTY} state_t;

  state_t state, state_nxt;
  logic   alive;

  logic [DATA_W-1:0] a_val_p0;
  logic [IDX_W-1:0]  a_row_p0;
  logic              a_last_p0;
  logic [ADDR_W-1:0] cur_p0, end_p0, cur_inc;

  logic vld_p1, last_p1;

  logic [DATA_W-1:0] fifo_val  [0:1];
  logic [IDX_W-1:0]  fifo_row  [0:1];
  logic [IDX_W-1:0]  fifo_col  [0:1];
  logic              fifo_last [0:1];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [IDX_W-1:0]  last_col;

  logic              pop, push, snt_push, slot_free;
  logic [2:0]        occ;
  logic [DATA_W-1:0] push_val;
  logic [IDX_W-1:0]  push_col;
  logic              push_last;

  function automatic logic [DATA_W-1:0] trunc_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = a * b;
    return full[DATA_W-1:0];
  endfunction

  assign cur_inc   = cur_p0 + ADDR_W'(1);
  assign pop       = out_valid && out_ready;
  // Reads in flight count as occupied so a returning read always finds a slot.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign slot_free = (occ < 3'd2);

  assign ptr_rd_addr = a_col;
  assign b_rd_addr   = cur_p0;

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    ptr_rd_en = 1'b0;
    b_rd_en   = 1'b0;
    snt_push  = 1'b0;
    case (state)
      S_IDLE: begin
        a_ready = alive;
        if (a_valid && alive) begin
          ptr_rd_en = 1'b1;
          state_nxt = S_PTR;
        end
      end
      S_PTR: begin
        if (ptr_end <= ptr_start) state_nxt = a_last_p0 ? S_EMPTY : S_IDLE;
        else                      state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (slot_free) begin
          b_rd_en = 1'b1;
          if (cur_inc == end_p0) state_nxt = S_IDLE;
        end
      end
      S_EMPTY: begin
        if (slot_free) begin
          snt_push  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: A element and row-walk registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ptr_rd_en) begin
      a_val_p0  <= a_val;
      a_row_p0  <= a_row;
      a_last_p0 <= a_last;
    end
    if (state == S_PTR) begin
      cur_p0 <= ptr_start;
      end_p0 <= ptr_end;
    end else if (b_rd_en) begin
      cur_p0 <= cur_inc;
    end
  end

  // p1: B read in flight, data returns this stage
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= b_rd_en;
  end

  always_ff @(posedge clk) begin
    if (b_rd_en) last_p1 <= a_last_p0 && (cur_inc == end_p0);
  end

  assign push      = vld_p1 || snt_push;
  assign push_val  = vld_p1 ? trunc_mul(a_val_p0, b_val) : '0;
  assign push_col  = vld_p1 ? b_col : last_col;
  assign push_last = vld_p1 ? last_p1 : 1'b1;

  // p2: output FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      last_col <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        last_col <= push_col;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_val[wr_ptr]  <= push_val;
      fifo_row[wr_ptr]  <= a_row_p0;
      fifo_col[wr_ptr]  <= push_col;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_val   = fifo_val[rd_ptr];
  assign out_row   = fifo_row[rd_ptr];
  assign out_col   = fifo_col[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_pp_gen_row_stream.sv
// Scoreboard bench for pp_gen_row_stream: a CSR memory model answers the pointer and
// B reads, expected products are queued when A is sent and checked at each handshake.
module tb_pp_gen_row_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, a_last;
  logic [31:0] a_val;
  logic [15:0] a_row, a_col;
  logic        ptr_rd_en, b_rd_en;
  logic [15:0] ptr_rd_addr, ptr_start, ptr_end, b_rd_addr, b_col;
  logic [31:0] b_val;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_val;
  logic [15:0] out_row, out_col;

  typedef struct packed {
    logic [31:0] val;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] rowptr [0:16];
  logic [31:0] bmem_val [0:63];
  logic [15:0] bmem_col [0:63];
  logic [15:0] tb_last_col;

  pp_gen_row_stream #(.DATA_W(32), .IDX_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_val(a_val), .a_row(a_row),
    .a_col(a_col), .a_last(a_last),
    .ptr_rd_en(ptr_rd_en), .ptr_rd_addr(ptr_rd_addr),
    .ptr_start(ptr_start), .ptr_end(ptr_end),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_val(b_val), .b_col(b_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency for both the row pointers and B nonzeros.
  always @(posedge clk) begin
    if (ptr_rd_en) begin
      ptr_start <= rowptr[ptr_rd_addr[3:0]];
      ptr_end   <= rowptr[ptr_rd_addr[3:0] + 5'd1];
    end
    if (b_rd_en) begin
      b_val <= bmem_val[b_rd_addr[5:0]];
      b_col <= bmem_col[b_rd_addr[5:0]];
    end
  end

  // Monitor: handshake scoreboard, stall stability and FIFO occupancy.
  int          pending = 0;
  int          popi;
  logic        held_vld = 1'b0;
  exp_t        held, e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending  = 0;
      held_vld = 1'b0;
    end else begin
      popi = (out_valid && out_ready) ? 1 : 0;
      if (held_vld) begin
        checks++;
        if (out_valid !== 1'b1 || {out_val, out_row, out_col, out_last} !== held) begin
          fails++;
          $display("FAIL hold: got v=%0b %0d r%0d c%0d l%0b, required v=1 %0d r%0d c%0d l%0b",
                   out_valid, out_val, out_row, out_col, out_last,
                   held.val, held.row, held.col, held.last);
        end
      end
      held_vld = out_valid && !out_ready;
      if (held_vld) held = {out_val, out_row, out_col, out_last};
      if (b_rd_en) begin
        checks++;
        if (pending - popi >= 2) begin
          fails++;
          $display("FAIL overflow: b_rd_en with %0d entries outstanding, required < 2",
                   pending - popi);
        end
      end
      if (popi == 1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %0d r%0d c%0d l%0b, required no output",
                   out_val, out_row, out_col, out_last);
        end else begin
          e = sb.pop_front();
          if ({out_val, out_row, out_col, out_last} !== e) begin
            fails++;
            $display("FAIL product: got %0d r%0d c%0d l%0b, required %0d r%0d c%0d l%0b",
                     out_val, out_row, out_col, out_last, e.val, e.row, e.col, e.last);
          end
        end
      end
      pending = pending + (b_rd_en ? 1 : 0) - popi;
      if (pending < 0) pending = 0;
    end
  end

  task automatic send_a(input logic [31:0] v, input logic [15:0] r, input logic [15:0] k,
                        input logic l);
    logic [15:0] s, en;
    logic [63:0] prod;
    bit          done;
    s  = rowptr[k[3:0]];
    en = rowptr[k[3:0] + 5'd1];
    if (en > s) begin
      for (int ad = int'(s); ad < int'(en); ad++) begin
        prod = v * bmem_val[ad];
        sb.push_back({prod[31:0], r, bmem_col[ad], l && (ad == int'(en) - 1)});
        tb_last_col = bmem_col[ad];
      end
    end else if (l) begin
      sb.push_back({32'd0, r, tb_last_col, 1'b1});
    end
    a_val = v; a_row = r; a_col = k; a_last = l; a_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (a_ready) done = 1;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL a_accept_timeout: a_ready never seen, required 1 within 50 cycles");
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid && a_ready) break;
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected products missing, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; out_ready = 1'b1;
    a_val = '0; a_row = '0; a_col = '0; a_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (a_ready   !== 1'b0) begin fails++; $display("FAIL rst_a_ready: got %b, required 0", a_ready); end
    if (ptr_rd_en !== 1'b0) begin fails++; $display("FAIL rst_ptr_rd_en: got %b, required 0", ptr_rd_en); end
    if (b_rd_en   !== 1'b0) begin fails++; $display("FAIL rst_b_rd_en: got %b, required 0", b_rd_en); end
    if (out_last  !== 1'b0) begin fails++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL rst_release_a_ready: got %b, required 1", a_ready); end
  endtask

  task automatic test_basic();
    int n;
    rowptr[2] = 16'd0; rowptr[3] = 16'd2;
    bmem_val[0] = 32'd5; bmem_col[0] = 16'd1;
    bmem_val[1] = 32'd7; bmem_col[1] = 16'd4;
    send_a(32'd3, 16'd0, 16'd2, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
    checks++;
    if (n != 3) begin fails++; $display("FAIL latency: got %0d cycles, required 3", n); end
    drain("basic");
  endtask

  task automatic load_long_row();
    logic [15:0] cols [0:5];
    cols[0] = 16'd0; cols[1] = 16'd2; cols[2] = 16'd3;
    cols[3] = 16'd5; cols[4] = 16'd7; cols[5] = 16'd9;
    rowptr[5] = 16'd10; rowptr[6] = 16'd16;
    for (int i = 0; i < 6; i++) begin
      bmem_val[10 + i] = 32'h1000_0001 * (i + 1);
      bmem_col[10 + i] = cols[i];
    end
  endtask

  task automatic test_long_row();
    int n;
    load_long_row();
    send_a(32'd7, 16'd2, 16'd5, 1'b0);
    for (int i = 0; i < 10 && !out_valid; i++) begin @(posedge clk); #1; end
    n = 0;
    while (out_valid && n < 20) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != 6) begin fails++; $display("FAIL no_bubble: got %0d consecutive valid cycles, required 6", n); end
    drain("long_row");
  endtask

  task automatic test_stall();
    load_long_row();
    fork
      begin
        send_a(32'hFFFF_FFF3, 16'd3, 16'd5, 1'b0);
        drain("stall");
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 3 == 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic test_empty_last();
    rowptr[8] = 16'd30; rowptr[9] = 16'd25;
    rowptr[6] = 16'd20; rowptr[7] = 16'd20;
    send_a(32'd99, 16'd4, 16'd8, 1'b0);
    send_a(32'd11, 16'd4, 16'd6, 1'b1);
    drain("empty_last");
  endtask

  task automatic test_back_to_back();
    rowptr[0] = 16'd40; rowptr[1] = 16'd41; rowptr[2] = 16'd42;
    bmem_val[40] = 32'd4; bmem_col[40] = 16'd3;
    bmem_val[41] = 32'd8; bmem_col[41] = 16'd0;
    send_a(32'd2, 16'd1, 16'd0, 1'b0);
    send_a(32'd1, 16'd1, 16'd1, 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int seen;
    rowptr[3] = 16'd50; rowptr[4] = 16'd58;
    for (int i = 0; i < 8; i++) begin
      bmem_val[50 + i] = 32'd100 + i; bmem_col[50 + i] = 16'(2 * i);
    end
    out_ready = 1'b0;
    send_a(32'd2, 16'd6, 16'd3, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out_valid: got %b, required 0", out_valid); end
    if (a_ready   !== 1'b0) begin fails++; $display("FAIL mid_rst_a_ready: got %b, required 0", a_ready); end
    if (out_last  !== 1'b0) begin fails++; $display("FAIL mid_rst_out_last: got %b, required 0", out_last); end
    sb.delete();
    tb_last_col = '0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_release: got a_ready=%b, required 1", a_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL stale_output: got %0d valid cycles, required 0", seen); end
    send_a(32'd5, 16'd7, 16'd0, 1'b1);
    drain("after_reset");
  endtask

  initial begin
    tb_last_col = '0;
    for (int i = 0; i < 17; i++) rowptr[i] = '0;
    for (int i = 0; i < 64; i++) begin bmem_val[i] = '0; bmem_col[i] = '0; end
    test_reset();
    test_basic();
    test_long_row();
    test_stall();
    test_empty_last();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
